sram_xbar_n: RTL and testbench

- N-slave address-decoded router for the SoC's single-port SRAM-style data bus: one master (pipeline data port) to NUM_SLAVES slaves (data RAM, UART, board IO, future devices).
- Replaces cascaded 2-way xbars with one parametrised block.
- Decodes by base/mask table, pipelines the slave select to match slave read latency, and answers unmapped accesses with a default word plus an error indication.

---
 rtl/sram_xbar_pkg.sv | 26 ++
 rtl/sram_xbar_sel_pipe.sv | 21 ++
 rtl/sram_xbar_n.sv | 113 +++++++++++
 tb/tb_sram_xbar_n.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/sram_xbar_pkg.sv
// sram_xbar_pkg: shared types and the base/mask decode helper for the sram_xbar_n router.
package sram_xbar_pkg;
    localparam int MAX_SLAVES = 16;
    localparam int MAX_ADDR_W = 64;
    typedef struct packed {
        logic       valid;
        logic       hit;
        logic [3:0] idx;
    } sel_stage_t;
    function automatic sel_stage_t slave_decode(
        input logic [MAX_ADDR_W-1:0]            addr,
        input logic [MAX_SLAVES*MAX_ADDR_W-1:0] base,
        input logic [MAX_SLAVES*MAX_ADDR_W-1:0] mask,
        input int                               num
    );
        sel_stage_t s;
        s = '0;
        // Scan downwards so the lowest matching index is the one left standing.
        for (int i = MAX_SLAVES - 1; i >= 0; i--)
            if (i < num && (addr & mask[i*MAX_ADDR_W +: MAX_ADDR_W]) == base[i*MAX_ADDR_W +: MAX_ADDR_W]) begin
                s.hit = 1'b1;
                s.idx = 4'(i);
            end
        return s;
    endfunction
endpackage

// File: rtl/sram_xbar_sel_pipe.sv
// sram_xbar_sel_pipe: DEPTH-stage shift register that carries per-access state until its read data matures.
module sram_xbar_sel_pipe import sram_xbar_pkg::*; #(
    parameter int  DEPTH = 1,
    parameter type T     = sel_stage_t
) (
    input  logic clk,
    input  logic rst,
    input  T     d_i,
    output T     q_o
);
    T stage_q [DEPTH];
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
    end
    assign q_o = stage_q[DEPTH-1];
endmodule

// File: rtl/sram_xbar_n.sv
// sram_xbar_n: one-master to NUM_SLAVES SRAM-bus router with base/mask decode and pipelined read select.
// Define SRAM_XBAR_ERR_CAPTURE_EN to build the unmapped-access capture registers (err_addr/err_we/err_count).
module sram_xbar_n import sram_xbar_pkg::*; #(
    parameter int                             LEN_ADDR      = 64,
    parameter int                             LEN_DATA      = 64,
    parameter int                             NUM_SLAVES    = 4,
    parameter logic [NUM_SLAVES*LEN_ADDR-1:0] SLAVE_BASE    = '0,
    parameter logic [NUM_SLAVES*LEN_ADDR-1:0] SLAVE_MASK    = '0,
    parameter int                             RD_LATENCY    = 1,
    parameter logic [LEN_DATA-1:0]            DEFAULT_RDATA = LEN_DATA'(32'hDEADBEEF)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [LEN_ADDR-1:0]                master_addra,
    input  logic [LEN_DATA-1:0]                master_dina,
    output logic [LEN_DATA-1:0]                master_douta,
    input  logic                               master_ena,
    input  logic [LEN_DATA/8-1:0]              master_wea,
    output logic [NUM_SLAVES*LEN_ADDR-1:0]     slave_addra,
    output logic [NUM_SLAVES*LEN_DATA-1:0]     slave_dina,
    input  logic [NUM_SLAVES*LEN_DATA-1:0]     slave_douta,
    output logic [NUM_SLAVES-1:0]              slave_ena,
    output logic [NUM_SLAVES*LEN_DATA/8-1:0]   slave_wea,
    output logic                               err_pulse,
    input  logic                               err_clr,
    output logic [LEN_ADDR-1:0]                err_addr,
    output logic                               err_we,
    output logic [7:0]                         err_count
);
    localparam int LEN_BE = LEN_DATA / 8;
    function automatic logic [MAX_SLAVES*MAX_ADDR_W-1:0] widen(input logic [NUM_SLAVES*LEN_ADDR-1:0] v);
        widen = '0;
        for (int i = 0; i < NUM_SLAVES; i++)
            widen[i*MAX_ADDR_W +: MAX_ADDR_W] = MAX_ADDR_W'(v[i*LEN_ADDR +: LEN_ADDR]);
    endfunction
    localparam logic [MAX_SLAVES*MAX_ADDR_W-1:0] BASE_W = widen(SLAVE_BASE);
    localparam logic [MAX_SLAVES*MAX_ADDR_W-1:0] MASK_W = widen(SLAVE_MASK);

    sel_stage_t              stage_d, last, resp_q, resp_d;
    logic [NUM_SLAVES-1:0]   sel;

    always_comb begin
        stage_d       = slave_decode(MAX_ADDR_W'(master_addra), BASE_W, MASK_W, NUM_SLAVES);
        stage_d.valid = master_ena;
    end

    assign slave_addra = {NUM_SLAVES{master_addra}};
    assign slave_dina  = {NUM_SLAVES{master_dina}};
    assign slave_ena   = {NUM_SLAVES{master_ena}} & sel;
    for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_slv
        assign sel[i]                         = stage_d.hit && stage_d.idx == 4'(i);
        assign slave_wea[i*LEN_BE +: LEN_BE] = sel[i] ? master_wea : '0;
    end

    sram_xbar_sel_pipe #(.DEPTH(RD_LATENCY), .T(sel_stage_t)) u_sel_pipe (
        .clk (clk),
        .rst (rst),
        .d_i (stage_d),
        .q_o (last)
    );

    // A maturing access steers douta this cycle; otherwise douta keeps following the last slave.
    assign resp_d = last.valid ? last : resp_q;
    always_ff @(posedge clk) begin
        if (rst) resp_q <= '0;
        else     resp_q <= resp_d;
    end
    assign master_douta = !resp_d.valid ? '0 :
                          resp_d.hit    ? slave_douta[int'(resp_d.idx)*LEN_DATA +: LEN_DATA] : DEFAULT_RDATA;
    assign err_pulse    = last.valid & ~last.hit & ~rst;

`ifdef SRAM_XBAR_ERR_CAPTURE_EN
    logic [LEN_ADDR:0]   cap_last;
    logic [LEN_ADDR-1:0] err_addr_q, err_addr_d;
    logic                err_we_q, err_we_d;
    logic [7:0]          err_count_q, err_count_d;

    sram_xbar_sel_pipe #(.DEPTH(RD_LATENCY), .T(logic [LEN_ADDR:0])) u_cap_pipe (
        .clk (clk),
        .rst (rst),
        .d_i ({|master_wea, master_addra}),
        .q_o (cap_last)
    );

    // A zero count means nothing is captured yet, so a clear and a new error together re-arm and capture.
    always_comb begin
        err_count_d             = err_clr ? 8'd0 : err_count_q;
        {err_we_d, err_addr_d}  = err_clr ? '0 : {err_we_q, err_addr_q};
        if (err_pulse && err_count_d == 8'd0) {err_we_d, err_addr_d} = cap_last;
        if (err_pulse && err_count_d != 8'hFF) err_count_d = err_count_d + 8'd1;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            err_addr_q  <= '0;
            err_we_q    <= 1'b0;
            err_count_q <= '0;
        end else begin
            err_addr_q  <= err_addr_d;
            err_we_q    <= err_we_d;
            err_count_q <= err_count_d;
        end
    end
    assign err_addr  = err_addr_q;
    assign err_we    = err_we_q;
    assign err_count = err_count_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign err_addr       = '0;
    assign err_we         = 1'b0;
    assign err_count      = '0;
`endif
endmodule

// File: tb/tb_sram_xbar_n.sv
// tb_sram_xbar_n: scoreboard bench for sram_xbar_n at read latency 1 and 3.
module tb_sram_xbar_n;
`ifdef SRAM_XBAR_ERR_CAPTURE_EN
    localparam bit CAP = 1'b1;
`else
    localparam bit CAP = 1'b0;
`endif
    localparam logic [191:0] BASE  = {64'h6400_0000, 64'h6000_0000, 64'h8000_0000};
    localparam logic [191:0] MASK1 = {64'hFF00_0000, 64'hFF00_0000, 64'hF000_0000};
    localparam logic [191:0] MASK3 = {64'hFF00_0000, 64'hF000_0000, 64'hF000_0000};
    localparam logic [63:0]  DEAD  = 64'hDEADBEEF;

    typedef struct { logic [63:0] d; logic e; } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    exp_t q1[$];
    exp_t q3[$];

    logic         rst1, ena1, ep1, clr1, ew1;
    logic [63:0]  addr1, din1, douta1, ea1;
    logic [7:0]   wea1, ec1;
    logic [191:0] sa1, sdi1, sdo1;
    logic [2:0]   sen1;
    logic [23:0]  swe1;
    logic         rst3, ena3, ep3, clr3, ew3;
    logic [63:0]  addr3, din3, douta3, ea3;
    logic [7:0]   wea3, ec3;
    logic [191:0] sa3, sdi3, sdo3;
    logic [2:0]   sen3;
    logic [23:0]  swe3;

    sram_xbar_n #(.LEN_ADDR(64), .LEN_DATA(64), .NUM_SLAVES(3), .SLAVE_BASE(BASE), .SLAVE_MASK(MASK1),
                  .RD_LATENCY(1), .DEFAULT_RDATA(DEAD)) u1 (
        .clk(clk), .rst(rst1), .master_addra(addr1), .master_dina(din1), .master_douta(douta1),
        .master_ena(ena1), .master_wea(wea1), .slave_addra(sa1), .slave_dina(sdi1), .slave_douta(sdo1),
        .slave_ena(sen1), .slave_wea(swe1), .err_pulse(ep1), .err_clr(clr1), .err_addr(ea1),
        .err_we(ew1), .err_count(ec1));

    sram_xbar_n #(.LEN_ADDR(64), .LEN_DATA(64), .NUM_SLAVES(3), .SLAVE_BASE(BASE), .SLAVE_MASK(MASK3),
                  .RD_LATENCY(3), .DEFAULT_RDATA(DEAD)) u3 (
        .clk(clk), .rst(rst3), .master_addra(addr3), .master_dina(din3), .master_douta(douta3),
        .master_ena(ena3), .master_wea(wea3), .slave_addra(sa3), .slave_dina(sdi3), .slave_douta(sdo3),
        .slave_ena(sen3), .slave_wea(swe3), .err_pulse(ep3), .err_clr(clr3), .err_addr(ea3),
        .err_we(ew3), .err_count(ec3));

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    // Response-due markers: one per issued access, delayed by the read latency, flushed by reset.
    logic       due1 = 1'b0;
    logic [2:0] due3 = 3'b0;
    always @(posedge clk) begin
        due1 <= rst1 ? 1'b0 : ena1;
        due3 <= rst3 ? 3'b0 : {due3[1:0], ena3};
    end

    always @(negedge clk) begin
        exp_t e;
        if (due1) begin
            if (q1.size() == 0) chk("sb1_underflow", 64'd1, 64'd0);
            else begin
                e = q1.pop_front();
                chk("douta1", douta1, e.d);
                chk("err_pulse1", {63'd0, ep1}, {63'd0, e.e});
            end
        end else chk("err_pulse1_idle", {63'd0, ep1}, 64'd0);
    end

    always @(negedge clk) begin
        exp_t e;
        if (due3[2]) begin
            if (q3.size() == 0) chk("sb3_underflow", 64'd1, 64'd0);
            else begin
                e = q3.pop_front();
                chk("douta3", douta3, e.d);
                chk("err_pulse3", {63'd0, ep3}, {63'd0, e.e});
            end
        end else chk("err_pulse3_idle", {63'd0, ep3}, 64'd0);
    end

    task automatic acc1(input logic [63:0] a, input logic [7:0] we, input logic [63:0] d, input logic e);
        @(posedge clk); #1;
        ena1 = 1'b1; addr1 = a; wea1 = we;
        q1.push_back('{d, e});
    endtask
    task automatic idle1();
        @(posedge clk); #1;
        ena1 = 1'b0; wea1 = '0;
    endtask
    task automatic acc3(input logic [63:0] a, input logic [63:0] d, input logic e);
        @(posedge clk); #1;
        ena3 = 1'b1; addr3 = a; wea3 = '0;
        q3.push_back('{d, e});
    endtask
    task automatic idle3();
        @(posedge clk); #1;
        ena3 = 1'b0; wea3 = '0;
    endtask

    initial begin
        rst1 = 1'b1; ena1 = 1'b0; addr1 = '0; din1 = 64'h55; wea1 = '0; clr1 = 1'b0;
        rst3 = 1'b1; ena3 = 1'b0; addr3 = '0; din3 = 64'h77; wea3 = '0; clr3 = 1'b0;
        sdo1 = {64'h3333, 64'h2222, 64'h1111};
        sdo3 = {64'hC3C3, 64'hB3B3, 64'hA3A3};
        repeat (2) @(posedge clk);
        #1; rst1 = 1'b0; rst3 = 1'b0;
        @(negedge clk);
        chk("rst_douta", douta1, 64'd0);
        chk("rst_err_addr", ea1, 64'd0);
        chk("rst_err_we", {63'd0, ew1}, 64'd0);
        chk("rst_err_count", {56'd0, ec1}, 64'd0);

        acc1(64'h8000_0010, 8'h00, 64'h1111, 1'b0);
        @(negedge clk); chk("ena_slave0", {61'd0, sen1}, 64'b001);
        idle1();
        sdo1[64 +: 64] = 64'h2AAA;
        idle1(); idle1();
        @(negedge clk); chk("douta_hold", douta1, 64'h1111);

        sdo1 = {64'hC2C2, 64'hB1B1, 64'hA0A0};
        acc1(64'h6000_0000, 8'h00, 64'hB1B1, 1'b0);
        acc1(64'h6400_0008, 8'h00, 64'hC2C2, 1'b0);
        @(negedge clk); chk("ena_slave2", {61'd0, sen1}, 64'b100);
        acc1(64'h8000_0000, 8'h00, 64'hA0A0, 1'b0);
        idle1(); idle1();

        acc1(64'h1000_0000, 8'hFF, DEAD, 1'b1);
        @(negedge clk);
        chk("unmapped_wr_ena", {61'd0, sen1}, 64'd0);
        chk("unmapped_wr_wea", {40'd0, swe1}, 64'd0);
        idle1(); idle1();
        @(negedge clk);
        chk("cap_addr_first", ea1, CAP ? 64'h1000_0000 : 64'd0);
        chk("cap_we_first", {63'd0, ew1}, CAP ? 64'd1 : 64'd0);
        chk("cap_count_first", {56'd0, ec1}, CAP ? 64'd1 : 64'd0);

        acc1(64'h2000_0000, 8'h00, DEAD, 1'b1);
        for (int i = 0; i < 300; i++) acc1(64'h3000_0000 + 64'(i * 8), 8'h00, DEAD, 1'b1);
        idle1(); idle1();
        @(negedge clk);
        chk("cap_count_sat", {56'd0, ec1}, CAP ? 64'd255 : 64'd0);
        chk("cap_addr_kept", ea1, CAP ? 64'h1000_0000 : 64'd0);
        chk("cap_we_kept", {63'd0, ew1}, CAP ? 64'd1 : 64'd0);

        acc1(64'h4000_0000, 8'h00, DEAD, 1'b1);
        @(posedge clk); #1; ena1 = 1'b0; clr1 = 1'b1;
        @(posedge clk); #1; clr1 = 1'b0;
        @(negedge clk);
        chk("clr_count", {56'd0, ec1}, CAP ? 64'd1 : 64'd0);
        chk("clr_addr", ea1, CAP ? 64'h4000_0000 : 64'd0);
        chk("clr_we", {63'd0, ew1}, 64'd0);
        idle1();
        @(negedge clk); chk("sb1_empty", 64'(q1.size()), 64'd0);

        @(posedge clk); #1; ena3 = 1'b1; addr3 = 64'h2000_0000;
        @(posedge clk); #1; ena3 = 1'b0; rst3 = 1'b1;
        @(posedge clk); #1; rst3 = 1'b0;
        repeat (3) begin
            @(negedge clk); chk("rst_flush_douta3", douta3, 64'd0);
        end
        acc3(64'h6400_0000, 64'hB3B3, 1'b0);
        @(negedge clk); chk("overlap_ena", {61'd0, sen3}, 64'b010);
        acc3(64'h8000_0004, 64'hA3A3, 1'b0);
        repeat (5) idle3();
        @(negedge clk); chk("sb3_empty", 64'(q3.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
